// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The arbiter uses the slave view; the environment (requesters + memory) uses master.
interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  // Shared memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Pipeline holds
  logic              stall_if;
  logic              stall_dm;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_dm
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_dm
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one shared memory. Data port wins by default,
// but after STARVE_MAX consecutive data grants with a fetch waiting, fetch is served.
module mem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyDm,
    StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   starve_cnt_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic grant_dm;
  logic grant_if;

  // Data port wins unless the fetch port has been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_dm = bus.dm_req && (!bus.if_req || (starve_cnt_q < StarveMax));
    grant_if = bus.if_req && !grant_dm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant_dm) begin
            state_q     <= StBusyDm;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            if (bus.if_req) begin
              if (starve_cnt_q < StarveMax) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
              end
            end else begin
              starve_cnt_q <= '0;
            end
          end else if (grant_if) begin
            state_q      <= StBusyIf;
            mem_en_q     <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= bus.if_addr;
            starve_cnt_q <= '0;
          end
        end

        StBusyIf: begin
          if (bus.mem_ready) begin
            state_q    <= StDone;
            if_ack_q   <= 1'b1;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdata_q <= bus.mem_rdata;
          end
        end

        StBusyDm: begin
          if (bus.mem_ready) begin
            state_q  <= StDone;
            dm_ack_q <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            // Writes return nothing; keep the last read value visible.
            if (!mem_we_q) begin
              dm_rdata_q <= bus.mem_rdata;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_dm  = bus.dm_req & ~dm_ack_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32: data width of all data buses.
REQ-002 The block SHALL take parameter ADDR_W, default 32: width of all address buses.
REQ-003 The block SHALL take parameter STARVE_MAX, default 4: maximum consecutive data-port grants while a fetch request is waiting.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port if_req, input, 1 bit: fetch port request.
REQ-007 The block SHALL have port if_addr, input, ADDR_W bits: fetch address.
REQ-008 The block SHALL have port if_rdata, output, DATA_W bits: fetched word.
REQ-009 The block SHALL have port if_ack, output, 1 bit: fetch completion pulse.
REQ-010 The block SHALL have port dm_req, input, 1 bit: data port request.
REQ-011 The block SHALL have port dm_we, input, 1 bit: data port write (1) or read (0).
REQ-012 The block SHALL have port dm_addr, input, ADDR_W bits: data address.
REQ-013 The block SHALL have port dm_wdata, input, DATA_W bits: data to write.
REQ-014 The block SHALL have port dm_rdata, output, DATA_W bits: read data.
REQ-015 The block SHALL have port dm_ack, output, 1 bit: data completion pulse.
REQ-016 The block SHALL have port mem_en, output, 1 bit: memory access active.
REQ-017 The block SHALL have port mem_we, output, 1 bit: memory write strobe.
REQ-018 The block SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-019 The block SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-020 The block SHALL have port mem_rdata, input, DATA_W bits: memory read data.
REQ-021 The block SHALL have port mem_ready, input, 1 bit: memory completes the current access.
REQ-022 The block SHALL have port stall_if, output, 1 bit: hold for the fetch stage, equal to if_req & ~if_ack.
REQ-023 The block SHALL have port stall_dm, output, 1 bit: hold for the memory stage, equal to dm_req & ~dm_ack.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, BUSY_IF, BUSY_DM and DONE.
REQ-025 In IDLE, the arbiter SHALL move to BUSY_DM if dm_req=1 and (if_req=0 or starve_cnt<STARVE_MAX), else to BUSY_IF if if_req=1, else stay in IDLE.
REQ-026 On the transition out of IDLE, the arbiter SHALL latch the winner's address, plus write data and we for the data port, into mem_addr, mem_wdata and mem_we (mem_we=0 for fetch).
REQ-027 While in BUSY_IF or BUSY_DM, the arbiter SHALL hold mem_en=1 and keep mem_addr, mem_we and mem_wdata stable.
REQ-028 In BUSY_x with mem_ready=1, the arbiter SHALL go to DONE, pulse x_ack high for exactly the DONE cycle, and drop mem_en and mem_we in that cycle.
REQ-029 In BUSY_x, the arbiter SHALL capture mem_rdata into if_rdata (fetch) or dm_rdata (data read); a data write SHALL leave dm_rdata unchanged.
REQ-030 The rdata outputs SHALL hold their value until the next capture into the same output.
REQ-031 In BUSY_x with mem_ready=0, the arbiter SHALL stay in BUSY_x indefinitely; there is no timeout.
REQ-032 DONE SHALL go to IDLE unconditionally; requests SHALL NOT be sampled in DONE.
REQ-033 Requesters SHALL hold req, addr and wdata stable until ack, and may drop or renew req in the cycle after ack.
REQ-034 Minimum latency SHALL be: req seen in IDLE at cycle 0, BUSY at cycle 1 with mem_ready=1, ack at cycle 2, and the next grant decided at cycle 3.
REQ-035 A request arriving while the FSM is not in IDLE SHALL wait and be arbitrated at the next IDLE.
REQ-036 starve_cnt SHALL be $clog2(STARVE_MAX+1) bits wide, increment on a DM grant made while if_req=1, saturating at STARVE_MAX.
REQ-037 starve_cnt SHALL clear to 0 on any IF grant or any DM grant made while if_req=0.
REQ-038 When starve_cnt=STARVE_MAX and both requests are high, the arbiter SHALL grant IF.
REQ-039 The arbiter SHALL never assert if_ack and dm_ack in the same cycle, and SHALL never assert mem_we in BUSY_IF.

Reset
REQ-040 With rst_n=0 at a clock edge, the block SHALL set state=IDLE and starve_cnt=0.
REQ-041 With rst_n=0 at a clock edge, the block SHALL clear if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, if_rdata and dm_rdata to 0.
REQ-042 Reset asserted mid-access SHALL abort the access, with mem_en=0 from the next edge and no ack issued.
REQ-043 After rst_n returns to 1, arbitration SHALL resume from IDLE on the following edge.

Verification
REQ-044 Single fetch: if_req=1, if_addr=0x10, mem_ready=1 one cycle after mem_en, mem_rdata=0xDEADBEEF -> if_ack at cycle 2, if_rdata=0xDEADBEEF, mem_we=0 throughout.
REQ-045 Simultaneous requests: if_req=dm_req=1 with starve_cnt=0 -> DM granted first (dm_ack), IF granted at the next IDLE, and starve_cnt=0 after the IF grant.
REQ-046 Starvation: dm_req held high and renewed each cycle after ack, if_req high, STARVE_MAX=4 -> exactly 4 dm_acks, then 1 if_ack.
REQ-047 Wait states: dm write to 0x20 with data 0x55AA with mem_ready low for 5 cycles -> mem_en/mem_we/mem_addr/mem_wdata stable for 6 cycles, dm_ack once, dm_rdata unchanged.
REQ-048 Reset mid-access: rst_n=0 during BUSY_DM -> mem_en=0 next cycle, no dm_ack, all outputs 0; after release a pending if_req is granted normally.
